nibble_serial_adder: RTL and testbench

//   Sequential wide adder built on the team's 4-bit carry-chain adder (a, b, cin -> s, co).

---
 rtl/nibble_serial_adder_pkg.sv | 17 +
 rtl/nibble_serial_adder_nibble_adder.sv | 27 ++
 rtl/nibble_serial_adder.sv | 150 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the FSM state encoding and the slice width.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int nibbles);
        return $clog2(nibbles) + 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_nibble_adder.sv
// 4-bit ripple-carry adder slice.
// Also exposes the carry into bit 3 so signed overflow can be derived.
module nibble_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic                co,
    output logic                c3,
    output logic [NIBBLE_W-1:0] s
);

    always_comb begin : ripple
        logic c;
        c  = cin;
        s  = '0;
        c3 = 1'b0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            if (i == NIBBLE_W - 1) c3 = c;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential wide adder: one 4-bit slice per cycle, LSB nibble first,
// with a registered carry and a valid/ready result handshake.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int WIDTH = NIBBLE_W * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CNT_W = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             ovf_r_q, ovf_r_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic [NIBBLE_W-1:0] na_s;
    logic                na_co;
    logic                na_c3;

    nibble_adder u_nibble_adder (
        .a   (a_sr_q[NIBBLE_W-1:0]),
        .b   (b_sr_q[NIBBLE_W-1:0]),
        .cin (carry_q),
        .co  (na_co),
        .c3  (na_c3),
        .s   (na_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        sum_sr_d    = sum_sr_q;
        ovf_r_d     = ovf_r_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    carry_d  = cin;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_sr_d   = a_sr_q >> NIBBLE_W;
                b_sr_d   = b_sr_q >> NIBBLE_W;
                carry_d  = na_co;
                sum_sr_d = sum_sr_q >> NIBBLE_W;
                sum_sr_d[WIDTH-1 -: NIBBLE_W] = na_s;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    ovf_r_d = na_c3 ^ na_co;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // First DONE cycle publishes the result; handshake follows.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    sum_d       = sum_sr_q;
                    cout_d      = carry_q;
                    ovf_d       = ovf_r_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            ovf_r_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_sr_q    <= sum_sr_d;
            ovf_r_q     <= ovf_r_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for the nibble-serial adder at NIBBLES=4.
// Expected results are hand-computed constants.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int checks = 0;
    int failures = 0;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one add, check latency and result, leave result unconsumed.
    task automatic issue(input string tag, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic vc,
                         input logic [W-1:0] es, input logic ec,
                         input logic eo);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_in_ready_wait"}, 32'(in_ready), 32'd1);
        a = va;
        b = vb;
        cin = vc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(N + 1));
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        issue("basic", 16'h0001, 16'h0003, 1'b0, 16'h0004, 1'b0, 1'b0);
        consume("basic");

        issue("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        consume("ripple");

        issue("mixed", 16'h5D3B, 16'hB3C5, 1'b1, 16'h1101, 1'b1, 1'b0);
        consume("mixed");

        issue("sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        consume("sovf");

        issue("bp", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a = 16'hAAAA;
            b = 16'h5555;
            in_valid = 1'b1;
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_sum", 32'(sum), 32'h2345);
            chk("bp_hold_cout", 32'(cout), 32'd0);
            chk("bp_hold_ovf", 32'(ovf), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        consume("bp");

        a = 16'h1111;
        b = 16'h2222;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("mid_rst_no_valid", 32'(out_valid), 32'd0);

        issue("post_rst", 16'h0002, 16'h0002, 1'b0, 16'h0004, 1'b0, 1'b0);
        consume("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
